// File: rtl/uart_tx_fifo_feeder.sv
// Byte FIFO plus a transmit sequencer for a UART transmitter.
// The host pushes bytes with wr_en. The sequencer pops one byte, pulses
// tx_start, and then waits for tx_done_tick before it pops the next byte.
module uart_tx_fifo_feeder #(
  parameter int DBIT   = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DBIT-1:0]   wr_data,
  input  logic              clr_overflow,
  input  logic              tx_done_tick,
  output logic [DBIT-1:0]   tx_din,
  output logic              tx_start,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              overflow
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

  state_t            state, state_nxt;
  logic [DBIT-1:0]   mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic              push, pop, start_nxt;

  // count never exceeds DEPTH, so its MSB alone marks the full condition
  assign full  = count[ADDR_W];
  assign empty = (count == '0);

  // A full FIFO drops the write even when a pop happens in the same cycle
  assign push = wr_en & ~full;

  // Storage array; reset does not clear it because stale entries are never read
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Pointers and occupancy; a simultaneous push and pop leaves count unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow flag; when a set and a clear coincide, the set wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              overflow <= 1'b0;
    else if (wr_en && full)  overflow <= 1'b1;
    else if (clr_overflow)   overflow <= 1'b0;
  end

  // Registered transmitter outputs; tx_din holds the last popped byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_din   <= '0;
      tx_start <= 1'b0;
    end else begin
      tx_start <= start_nxt;
      if (pop) tx_din <= mem[rd_ptr];
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next state; tx_done_tick is only honoured in WAIT
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!empty)      state_nxt = START;
      START:                    state_nxt = WAIT;
      WAIT:    if (tx_done_tick) state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  // FSM outputs; a pop in IDLE makes tx_start rise in the next cycle (START)
  always_comb begin
    pop       = (state == IDLE) && !empty;
    start_nxt = pop;
    busy      = (state != IDLE);
  end

endmodule

// File: tb/tb_uart_tx_fifo_feeder.sv
// Self-checking bench for uart_tx_fifo_feeder. Each accepted byte is pushed to
// a scoreboard queue, and a monitor pops the queue on every tx_start pulse.
module tb_uart_tx_fifo_feeder;

  logic       clk = 1'b0;
  logic       rst_n, wr_en, clr_overflow, tx_done_tick;
  logic [7:0] wr_data, tx_din;
  logic       tx_start, full, empty, busy, overflow;
  logic [4:0] count;

  logic [7:0] sb[$];
  int n_checks = 0, n_fail = 0;
  int n_starts = 0, n_done = 0, last_start = 0, cyc = 0;

  uart_tx_fifo_feeder #(.DBIT(8), .ADDR_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
    .clr_overflow(clr_overflow), .tx_done_tick(tx_done_tick),
    .tx_din(tx_din), .tx_start(tx_start), .full(full), .empty(empty),
    .count(count), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Monitor: every tx_start pulse must carry the oldest expected byte
  always @(negedge clk) begin
    logic [7:0] exp_b;
    if (rst_n && tx_start) begin
      n_starts++;
      last_start = cyc;
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL tx_byte: unexpected tx_start with tx_din=%h, scoreboard empty", tx_din);
      end else begin
        exp_b = sb.pop_front();
        if (tx_din !== exp_b) begin
          n_fail++;
          $display("FAIL tx_byte: tx_din=%h expected %h", tx_din, exp_b);
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic write_byte(input logic [7:0] b, input bit accepted);
    wr_en = 1'b1; wr_data = b;
    if (accepted) sb.push_back(b);
    step;
    wr_en = 1'b0;
  endtask

  // Transmitter stand-in: finishes n frames, ticking gap cycles after each start
  task automatic serve(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      int k = 0;
      while (n_starts <= n_done && k < 200) begin step; k++; end
      if (n_starts <= n_done) begin
        n_checks++; n_fail++;
        $display("FAIL serve_timeout: frame %0d never started (starts=%0d)", i, n_starts);
        return;
      end
      while (cyc < last_start + gap) step;
      tx_done_tick = 1'b1; step; tx_done_tick = 1'b0;
      n_done++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; wr_en = 1'b0; wr_data = '0; clr_overflow = 1'b0; tx_done_tick = 1'b0;
    sb.delete(); n_starts = 0; n_done = 0;
    repeat (2) step;
    n_checks++;
    if ({tx_din, tx_start, busy, overflow, count, empty, full} !== {8'h00, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_vals: din=%h start=%b busy=%b ovf=%b cnt=%0d empty=%b full=%b, want 00 0 0 0 0 1 0",
               tx_din, tx_start, busy, overflow, count, empty, full);
    end
    rst_n = 1'b1;
    step;
  endtask

  task automatic test_single;
    write_byte(8'hA5, 1'b1);
    n_checks++;
    if ({tx_start, empty, count} !== {1'b0, 1'b0, 5'd1}) begin
      n_fail++; $display("FAIL single_c1: start=%b empty=%b cnt=%0d want 0 0 1", tx_start, empty, count);
    end
    step;
    n_checks++;
    if ({tx_start, busy, empty} !== 3'b111) begin
      n_fail++; $display("FAIL single_c2: start=%b busy=%b empty=%b want 1 1 1", tx_start, busy, empty);
    end
    // Stray tick in START must be ignored
    tx_done_tick = 1'b1; step; tx_done_tick = 1'b0;
    n_checks++;
    if ({tx_start, busy} !== 2'b01) begin
      n_fail++; $display("FAIL single_c3: start=%b busy=%b want 0 1", tx_start, busy);
    end
    step;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL stray_tick: busy=%b want 1", busy);
    end
    tx_done_tick = 1'b1; step; tx_done_tick = 1'b0; n_done++;
    n_checks++;
    if ({busy, tx_din} !== {1'b0, 8'hA5}) begin
      n_fail++; $display("FAIL single_done: busy=%b din=%h want 0 a5", busy, tx_din);
    end
  endtask

  task automatic test_back_to_back;
    int base, tc, s;
    base = n_starts; tc = 0;
    write_byte(8'h11, 1'b1);
    write_byte(8'h22, 1'b1);
    write_byte(8'h33, 1'b1);
    for (int i = 0; i < 3; i++) begin
      int k = 0;
      while (n_starts <= n_done && k < 200) begin step; k++; end
      if (n_starts <= n_done) begin
        n_checks++; n_fail++;
        $display("FAIL b2b_timeout: frame %0d never started", i);
        return;
      end
      s = last_start;
      if (i > 0) begin
        n_checks++;
        if (s !== tc + 2) begin
          n_fail++; $display("FAIL b2b_latency: start at cycle %0d want %0d", s, tc + 2);
        end
      end
      while (cyc < s + 10) step;
      tx_done_tick = 1'b1; tc = cyc; step; tx_done_tick = 1'b0; n_done++;
    end
    repeat (15) step;
    n_checks++;
    if (n_starts - base !== 3) begin
      n_fail++; $display("FAIL b2b_pulses: %0d tx_start pulses want 3", n_starts - base);
    end
  endtask

  task automatic test_overflow;
    // 17 writes: 0x00 is popped at once and 0x01..0x10 fill all 16 slots
    for (int i = 0; i <= 16; i++) write_byte(8'(i), 1'b1);
    n_checks++;
    if ({full, count, overflow} !== {1'b1, 5'd16, 1'b0}) begin
      n_fail++; $display("FAIL ovf_fill: full=%b cnt=%0d ovf=%b want 1 16 0", full, count, overflow);
    end
    write_byte(8'h11, 1'b0);
    n_checks++;
    if ({overflow, count} !== {1'b1, 5'd16}) begin
      n_fail++; $display("FAIL ovf_set: ovf=%b cnt=%0d want 1 16", overflow, count);
    end
    clr_overflow = 1'b1; write_byte(8'h12, 1'b0); clr_overflow = 1'b0;
    n_checks++;
    if (overflow !== 1'b1) begin
      n_fail++; $display("FAIL ovf_set_wins: ovf=%b want 1", overflow);
    end
    clr_overflow = 1'b1; step; clr_overflow = 1'b0;
    n_checks++;
    if (overflow !== 1'b0) begin
      n_fail++; $display("FAIL ovf_clear: ovf=%b want 0", overflow);
    end
    serve(17, 3);
    n_checks++;
    if ({empty, count, int'(sb.size())} !== {1'b1, 5'd0, 32'd0}) begin
      n_fail++; $display("FAIL ovf_drain: empty=%b cnt=%0d pending=%0d want 1 0 0", empty, count, sb.size());
    end
  endtask

  task automatic test_full_pop;
    for (int i = 0; i <= 16; i++) write_byte(8'(8'h40 + i), 1'b1);
    n_checks++;
    if ({full, busy} !== 2'b11) begin
      n_fail++; $display("FAIL fp_full: full=%b busy=%b want 1 1", full, busy);
    end
    tx_done_tick = 1'b1; write_byte(8'hEE, 1'b0); tx_done_tick = 1'b0; n_done++;
    n_checks++;
    if ({overflow, count, busy} !== {1'b1, 5'd16, 1'b0}) begin
      n_fail++; $display("FAIL fp_drop: ovf=%b cnt=%0d busy=%b want 1 16 0", overflow, count, busy);
    end
    step;
    n_checks++;
    if (count !== 5'd15) begin
      n_fail++; $display("FAIL fp_pop: cnt=%0d want 15", count);
    end
    write_byte(8'h77, 1'b1);
    n_checks++;
    if (count !== 5'd16) begin
      n_fail++; $display("FAIL fp_refill: cnt=%0d want 16", count);
    end
    serve(17, 2);
    clr_overflow = 1'b1; step; clr_overflow = 1'b0;
    n_checks++;
    if ({empty, int'(sb.size())} !== {1'b1, 32'd0}) begin
      n_fail++; $display("FAIL fp_drain: empty=%b pending=%0d want 1 0", empty, sb.size());
    end
  endtask

  task automatic test_wrap;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          write_byte(8'(i + 100), 1'b1);
          repeat (3) step;
        end
      end
      serve(40, 3);
    join
    step;
    n_checks++;
    if ({empty, count, busy, int'(sb.size())} !== {1'b1, 5'd0, 1'b0, 32'd0}) begin
      n_fail++; $display("FAIL wrap_end: empty=%b cnt=%0d busy=%b pending=%0d want 1 0 0 0",
                         empty, count, busy, sb.size());
    end
  endtask

  task automatic test_async_reset;
    for (int i = 0; i < 6; i++) write_byte(8'(8'h60 + i), 1'b1);
    n_checks++;
    if ({count, busy} !== {5'd5, 1'b1}) begin
      n_fail++; $display("FAIL ar_pre: cnt=%0d busy=%b want 5 1", count, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({tx_din, tx_start, busy, overflow, count, empty, full} !== {8'h00, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL ar_vals: din=%h start=%b busy=%b ovf=%b cnt=%0d empty=%b full=%b, want 00 0 0 0 0 1 0",
               tx_din, tx_start, busy, overflow, count, empty, full);
    end
    sb.delete(); n_starts = 0; n_done = 0;
    step;
    rst_n = 1'b1;
    repeat (10) step;
    n_checks++;
    if (n_starts !== 0) begin
      n_fail++; $display("FAIL ar_quiet: %0d tx_start pulses after reset want 0", n_starts);
    end
    write_byte(8'h99, 1'b1);
    serve(1, 2);
    n_checks++;
    if ({n_starts, int'(sb.size())} !== {32'd1, 32'd0}) begin
      n_fail++; $display("FAIL ar_resume: starts=%0d pending=%0d want 1 0", n_starts, sb.size());
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_overflow;
    test_full_pop;
    test_wrap;
    test_async_reset;
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
